// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Memory-to-memory copy engine that drives a two-port, byte-lane word memory.
// It copies word_count 32-bit words from src_addr to dst_addr with memmove
// semantics, so overlapping regions are copied correctly. The copy runs
// descending when the destination starts inside the source block, and
// ascending otherwise. Each word takes two cycles: READ, then WRITE.
//
// Optional feature: define MEM_COPY_VERIFY_EN to add a VERIFY state after
// every WRITE. VERIFY reads the destination word back. On a mismatch it sets
// the sticky err output and aborts the transfer. Each word then costs three
// cycles. Without the macro, err is tied to 0.
//
// Ports
//   clk            clock; all state updates on posedge
//   rst            asynchronous active-high reset
//   start          copy request, sampled only when idle
//   src_addr       source byte address (bits [1:0] ignored)
//   dst_addr       destination byte address (bits [1:0] ignored)
//   word_count     number of words to copy (0 = no memory access)
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   err            sticky verify-mismatch flag (0 unless MEM_COPY_VERIFY_EN)
//   mem_addr1/2    memory port addresses (0 when the port is unused)
//   mem_data1/2_in memory write data (0 unless writing)
//   mem_we         write enable; both ports write the same word
//   mem_data1/2_out combinational memory read data
// -----------------------------------------------------------------------------
module mem_copy_engine #(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [CNT_W-1:0]     word_count,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [31:0]          mem_addr1,
   output logic [31:0]          mem_addr2,
   output logic [0:3][7:0]      mem_data1_in,
   output logic [0:3][7:0]      mem_data2_in,
   output logic                 mem_we,
   input  logic [0:3][7:0]      mem_data1_out,
   input  logic [0:3][7:0]      mem_data2_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_VERIFY,
      S_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [31:0]        cur_src_reg, cur_dst_reg;
   logic [CNT_W-1:0]   rem_reg;
   logic               desc_reg;
   logic [0:3][7:0]    buf_reg;

   logic               accept;    // start taken in IDLE
   logic               advance;   // word finished: step pointers, count down
   logic               last_word;

   // ------------------------------------------------------------------
   // Start-time address and direction computation
   // ------------------------------------------------------------------
   logic [31:0]        src_a, dst_a;
   logic [32:0]        src_end;   // 33 bits so src + 4*count cannot wrap
   logic [CNT_W-1:0]   cnt_m1;
   logic [31:0]        last_off;
   logic               go_desc;

   assign src_a    = {src_addr[31:2], 2'b00};
   assign dst_a    = {dst_addr[31:2], 2'b00};
   assign src_end  = {1'b0, src_a} + {{(31-CNT_W){1'b0}}, word_count, 2'b00};
   assign cnt_m1   = word_count - CNT_W'(1);
   assign last_off = {{(30-CNT_W){1'b0}}, cnt_m1, 2'b00};

   // The destination starts inside the source block. An ascending copy would
   // overwrite source words before they are read, so copy from the top down.
   assign go_desc  = (dst_a > src_a) && ({1'b0, dst_a} < src_end);

   assign last_word = (rem_reg == CNT_W'(1));

   // Bits of the inputs that the design does not use.
   logic unused_bits;
`ifdef MEM_COPY_VERIFY_EN
   assign unused_bits = ^{src_addr[1:0], dst_addr[1:0]};
`else
   assign unused_bits = ^{src_addr[1:0], dst_addr[1:0], mem_data1_out};
`endif

`ifdef MEM_COPY_VERIFY_EN
   logic mismatch;
   logic err_reg;
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      busy         = 1'b1;
      done         = 1'b0;
      mem_we       = 1'b0;
      mem_addr1    = 32'd0;
      mem_addr2    = 32'd0;
      mem_data1_in = '0;
      mem_data2_in = '0;
      accept       = 1'b0;
      advance      = 1'b0;
`ifdef MEM_COPY_VERIFY_EN
      mismatch     = 1'b0;
`endif
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept     = 1'b1;
               state_next = (word_count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            mem_addr2  = cur_src_reg;
            state_next = S_WRITE;
         end
         S_WRITE: begin
            // Both ports write the same word, so their write order does
            // not matter.
            mem_addr1    = cur_dst_reg;
            mem_addr2    = cur_dst_reg;
            mem_data1_in = buf_reg;
            mem_data2_in = buf_reg;
            mem_we       = 1'b1;
`ifdef MEM_COPY_VERIFY_EN
            state_next   = S_VERIFY;
`else
            advance      = 1'b1;
            state_next   = last_word ? S_DONE : S_READ;
`endif
         end
`ifdef MEM_COPY_VERIFY_EN
         S_VERIFY: begin
            mem_addr1 = cur_dst_reg;
            if (mem_data1_out != buf_reg) begin
               mismatch   = 1'b1;
               state_next = S_DONE;
            end else begin
               advance    = 1'b1;
               state_next = last_word ? S_DONE : S_READ;
            end
         end
`endif
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: pointers, remaining count, word buffer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_src_reg <= 32'd0;
         cur_dst_reg <= 32'd0;
         rem_reg     <= '0;
         desc_reg    <= 1'b0;
         buf_reg     <= '0;
      end else begin
         if (accept && (word_count != '0)) begin
            rem_reg  <= word_count;
            desc_reg <= go_desc;
            if (go_desc) begin
               cur_src_reg <= src_a + last_off;
               cur_dst_reg <= dst_a + last_off;
            end else begin
               cur_src_reg <= src_a;
               cur_dst_reg <= dst_a;
            end
         end
         if (state_reg == S_READ) begin
            buf_reg <= mem_data2_out;
         end
         if (advance) begin
            rem_reg     <= rem_reg - CNT_W'(1);
            cur_src_reg <= desc_reg ? cur_src_reg - 32'd4 : cur_src_reg + 32'd4;
            cur_dst_reg <= desc_reg ? cur_dst_reg - 32'd4 : cur_dst_reg + 32'd4;
         end
      end
   end

`ifdef MEM_COPY_VERIFY_EN
   // Sticky until reset or the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (accept) begin
         err_reg <= 1'b0;
      end else if (mismatch) begin
         err_reg <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

`ifdef MEM_COPY_VERIFY_EN
   localparam int CPW = 3;
`else
   localparam int CPW = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      src_addr = 32'd0;
   logic [31:0]      dst_addr = 32'd0;
   logic [7:0]       word_count = 8'd0;
   logic             busy, done, err, mem_we;
   logic [31:0]      mem_addr1, mem_addr2;
   logic [0:3][7:0]  mem_data1_in, mem_data2_in, mem_data1_out, mem_data2_out;

   always #5 clk = ~clk;

   mem_copy_engine #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
      .busy(busy), .done(done), .err(err),
      .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
      .mem_data1_in(mem_data1_in), .mem_data2_in(mem_data2_in),
      .mem_we(mem_we),
      .mem_data1_out(mem_data1_out), .mem_data2_out(mem_data2_out)
   );

   // Memory model: 64 words, combinational read, write at posedge.
   logic [31:0] mem [0:63];
   logic        tb_we = 1'b0;
   logic [5:0]  tb_widx = 6'd0;
   logic [31:0] tb_wdata = 32'd0;
   logic [31:0] corrupt_addr = 32'hFFFF_FFFF;

   assign mem_data1_out = mem[mem_addr1[7:2]];
   assign mem_data2_out = mem[mem_addr2[7:2]];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | i;
      forever begin
         @(posedge clk);
         if (mem_we) begin
            if (mem_addr1 == corrupt_addr)
               mem[mem_addr1[7:2]] <= mem_data1_in ^ 32'hFF00_0000;
            else
               mem[mem_addr1[7:2]] <= mem_data1_in;
         end else if (tb_we) begin
            mem[tb_widx] <= tb_wdata;
         end
      end
   end

   int checks = 0, passes = 0, fails = 0;
   int done_cycle, done_cnt, we_cnt, busy_cnt;
   logic [31:0] rd_addr [0:7];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] data);
      tb_widx = idx[5:0];
      tb_wdata = data;
      tb_we = 1'b1;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Start one copy and observe a bounded window of cycles after the
   // start-sampling edge. extra > 0 raises start again in that cycle.
   task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int extra);
      int maxc;
      maxc = CPW * n + 4;
      done_cycle = -1; done_cnt = 0; we_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 8; k++) rd_addr[k] = 32'hFFFF_FFFF;
      @(negedge clk);
      src_addr = s; dst_addr = d; word_count = n[7:0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= maxc; c++) begin
         if (busy) busy_cnt++;
         if (mem_we) we_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = c;
         end
         if (((c - 1) % CPW == 0) && ((c - 1) / CPW < 8)) rd_addr[(c - 1) / CPW] = mem_addr2;
         start = (c == extra);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_addr1", mem_addr1, 32'd0);
      check("rst_addr2", mem_addr2, 32'd0);
      check("rst_data1", mem_data1_in, 32'd0);
      check("rst_data2", mem_data2_in, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      poke(4, 32'h1111_1111);
      poke(5, 32'h2222_2222);
      poke(6, 32'h3333_3333);
      poke(7, 32'h4444_4444);
      poke(0, 32'hAAAA_AAAA);
      poke(1, 32'hBBBB_BBBB);
      poke(2, 32'hCCCC_CCCC);
      poke(3, 32'hDDDD_DDDD);

      // Basic 4-word copy 0x10 -> 0x40
      run(32'h10, 32'h40, 4, 0);
      check("basic_w0", mem[16], 32'h1111_1111);
      check("basic_w1", mem[17], 32'h2222_2222);
      check("basic_w2", mem[18], 32'h3333_3333);
      check("basic_w3", mem[19], 32'h4444_4444);
      check("basic_we_cycles", we_cnt, 4);
      check("basic_done_cycle", done_cycle, CPW * 4 + 1);
      check("basic_done_cnt", done_cnt, 1);
      check("basic_busy_cycles", busy_cnt, CPW * 4 + 1);
      check("basic_rd0", rd_addr[0], 32'h10);
      check("basic_rd3", rd_addr[3], 32'h1C);
      check("basic_err", {31'd0, err}, 32'd0);

      // Zero-length request
      run(32'h10, 32'h60, 0, 0);
      check("zero_done_cycle", done_cycle, 1);
      check("zero_we_cycles", we_cnt, 0);
      check("zero_busy_cycles", busy_cnt, 1);
      check("zero_mem", mem[24], 32'hDEAD_0018);

      // Overlapping copy, destination above source: descending
      run(32'h00, 32'h04, 3, 0);
      check("ovl_rd0", rd_addr[0], 32'h08);
      check("ovl_rd1", rd_addr[1], 32'h04);
      check("ovl_rd2", rd_addr[2], 32'h00);
      check("ovl_m0", mem[0], 32'hAAAA_AAAA);
      check("ovl_m1", mem[1], 32'hAAAA_AAAA);
      check("ovl_m2", mem[2], 32'hBBBB_BBBB);
      check("ovl_m3", mem[3], 32'hCCCC_CCCC);
      check("ovl_done_cycle", done_cycle, CPW * 3 + 1);

      // Unaligned addresses, second start while busy is ignored
      run(32'h13, 32'h22, 1, 1);
      check("unal_m8", mem[8], 32'h1111_1111);
      check("unal_rd0", rd_addr[0], 32'h10);
      check("unal_done_cnt", done_cnt, 1);
      check("unal_we_cycles", we_cnt, 1);
      check("unal_m9", mem[9], 32'hDEAD_0009);

      // Reset during the 3rd WRITE of a 4-word copy 0x10 -> 0x80
      @(negedge clk);
      src_addr = 32'h10; dst_addr = 32'h80; word_count = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2 * CPW + 1) @(negedge clk);
      check("mid_we_before", {31'd0, mem_we}, 32'd1);
      check("mid_addr_before", mem_addr1, 32'h88);
      rst = 1'b1;
      #1;
      check("mid_we_rst", {31'd0, mem_we}, 32'd0);
      check("mid_busy_rst", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("mid_m32", mem[32], 32'h1111_1111);
      check("mid_m33", mem[33], 32'h2222_2222);
      check("mid_m34", mem[34], 32'hDEAD_0022);
      check("mid_m35", mem[35], 32'hDEAD_0023);
      run(32'h10, 32'h80, 4, 0);
      check("after_m34", mem[34], 32'h3333_3333);
      check("after_m35", mem[35], 32'h4444_4444);
      check("after_done_cycle", done_cycle, CPW * 4 + 1);

`ifdef MEM_COPY_VERIFY_EN
      // Corrupt byte 0 of the 2nd destination word on write
      corrupt_addr = 32'hC4;
      run(32'h10, 32'hC0, 4, 0);
      check("ver_err", {31'd0, err}, 32'd1);
      check("ver_done_cycle", done_cycle, 7);
      check("ver_m48", mem[48], 32'h1111_1111);
      check("ver_m49", mem[49], 32'hDD22_2222);
      check("ver_m50", mem[50], 32'hDEAD_0032);
      corrupt_addr = 32'hFFFF_FFFF;
      run(32'h00, 32'h00, 0, 0);
      check("ver_err_clear", {31'd0, err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side DMA block that drives the two-port, byte-lane word memory. Copies a block of 32-bit words from a source region to a destination region.
- The CPU side programs it with start, src, dst and count; it raises a one-cycle done pulse when finished.
- Overlap-safe (memmove semantics), 2 cycles per word.

Parameters:
CNT_W, 8, width of the word-count input; maximum transfer is 2^CNT_W - 1 words

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
src_addr  input  32  source byte address; bits [1:0] ignored (forced 0)
dst_addr  input  32  destination byte address; bits [1:0] ignored
word_count  input  CNT_W  number of words to copy
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
mem_addr1  output  32  memory port-1 address
mem_addr2  output  32  memory port-2 address
mem_data1_in  output  8 x [0:3]  port-1 write bytes
mem_data2_in  output  8 x [0:3]  port-2 write bytes
mem_we  output  1  memory write enable (writes both ports)
mem_data1_out  input  8 x [0:3]  port-1 read bytes (combinational)
mem_data2_out  input  8 x [0:3]  port-2 read bytes (combinational)

Behaviour:
- Reset (asynchronous, immediate): state IDLE. busy=0, done=0, mem_we=0. All mem_addr* and mem_data*_in = 0. Internal pointers, counter and buffer cleared.
- States: IDLE, READ, WRITE, DONE (plus VERIFY when the optional feature is enabled).
- IDLE, start=1, word_count=0: go to DONE. No memory access.
- IDLE, start=1, word_count>0:
  - Latch src_a=src_addr&~3, dst_a=dst_addr&~3 and rem=word_count.
  - Direction: descending if dst_a > src_a and dst_a < src_a + 4*word_count (unsigned 33-bit compare); otherwise ascending.
  - Ascending: cur_src=src_a, cur_dst=dst_a, step +4.
  - Descending: cur_src=src_a+4*(count-1), cur_dst=dst_a+4*(count-1), step -4.
  - Go to READ.
- READ:
  - mem_addr2=cur_src, mem_we=0.
  - On the clock edge, buf <= mem_data2_out.
  - Go to WRITE.
- WRITE:
  - mem_addr1=mem_addr2=cur_dst, mem_data1_in=mem_data2_in=buf, mem_we=1. Both ports write the same word, so dual-port write ordering is irrelevant.
  - On the clock edge: rem--, cur_src+=step, cur_dst+=step (32-bit wrap, no bounds check).
  - If rem was 1, go to DONE; else go to READ.
- DONE: done=1 for exactly one cycle, busy=1. Then go to IDLE.
- Outputs are driven from state and registers (Moore). In IDLE, READ and DONE: mem_we=0 and mem_data*_in=0. Unused address ports are 0.
- Timing: for N>0 words, done is high in cycle 2N+1 after the start-sampling edge. For N=0, done is high in the first cycle after that edge.
- start while busy: ignored; no queuing. Inputs src_addr, dst_addr and word_count are don't-care after the start edge.
- src_a == dst_a: ascending; each word is rewritten with itself.
- Reset mid-transfer: mem_we drops immediately and the engine goes to IDLE. Memory keeps whatever words were already written.

Optional Feature:
- MEM_COPY_VERIFY_EN defined:
  - WRITE goes to VERIFY instead of READ/DONE. Pointer and count updates move to the VERIFY exit edge.
  - VERIFY: mem_addr1=cur_dst, mem_we=0, compare mem_data1_out against buf.
  - Mismatch: set sticky output err (1 bit, cleared by reset or the next accepted start) and go to DONE, aborting the transfer.
  - Match: continue as the WRITE exit normally would.
  - Per-word cost becomes 3 cycles.
- MEM_COPY_VERIFY_EN undefined: no VERIFY state, err port present and tied to 0, timing exactly as above.

Test Plan:
- Memory words 0x10..0x1C = 11111111, 22222222, 33333333, 44444444; start src=0x10, dst=0x40, count=4 -> 0x40..0x4C hold the same values; mem_we high exactly 4 cycles; done in cycle 9; busy high cycles 1-9.
- start count=0 -> done high in cycle 1; mem_we never asserted; memory unchanged.
- Overlap: words 0x00..0x0C = A, B, C, D; src=0x00, dst=0x04, count=3 -> read order 0x08, 0x04, 0x00; final 0x04..0x0C = A, B, C; 0x00 = A.
- Unaligned: src=0x13, dst=0x22, count=1 -> word at 0x10 copied to 0x20; second start pulse during busy ignored, single done.
- Reset asserted in the 3rd WRITE of a 4-word copy -> mem_we=0 and busy=0 immediately; 2 destination words updated, 3rd and 4th unchanged; a new start then behaves normally.
- MEM_COPY_VERIFY_EN defined, bench memory model corrupts byte 0 of the 2nd write -> err=1, done pulses after the 2nd VERIFY, 3rd word not written; next start clears err.
